tinyalu_responder: RTL and testbench
====================================

TINYALU_RESPONDER -- requirements
Module: tinyalu_responder

Interface
REQ-001: Parameter MUL_LATENCY, default 3, meaning: cycles from operand capture to done for mul_op; legal range 2..8.
REQ-002: clk  input  1  sole clock; all state changes on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004: A  input  8  operand A, unsigned.
REQ-005: B  input  8  operand B, unsigned.
REQ-006: op  input  3  opcode: 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 111 rst_op, 101/110 illegal.
REQ-007: start  input  1  request; held high by initiator until done is observed.
REQ-008: done  output  1  registered one-cycle completion pulse.
REQ-009: result  output  16  registered result; valid when done=1, held afterwards.

Function
REQ-010: FSM states SHALL be IDLE, BUSY, DONE, WAIT_LOW.
REQ-011: IDLE, start=1 at edge k, op in {001,010,011,100,101,110}: latch A, B, op into internal registers; go BUSY; load cycle counter.
REQ-012: IDLE, start=1 with op 000 or 111: no capture, no done, stay IDLE, result unchanged.
REQ-013: A, B, op changes after capture SHALL NOT affect the operation in flight.
REQ-014: Single-cycle ops (001, 010, 011, 101, 110): done=1 and result valid in the cycle after edge k+1.
REQ-015: mul_op: done=1 and result valid in the cycle after edge k+MUL_LATENCY; BUSY counts down, one decrement per cycle.
REQ-016: add_op result = {7'b0, 9-bit A+B}; carry preserved in bit 8.
REQ-017: and_op result = {8'b0, A&B}; xor_op result = {8'b0, A^B}.
REQ-018: mul_op result = full 16-bit unsigned A*B; no truncation.
REQ-019: Illegal ops 101/110 complete as single-cycle ops with result 16'h0000, so the initiator never hangs.
REQ-020: done SHALL be high for exactly one cycle per completed op (DONE state only).
REQ-021: DONE -> IDLE if start=0 at next edge, else DONE -> WAIT_LOW.
REQ-022: WAIT_LOW: done=0, no capture; -> IDLE on first edge with start=0 (start must drop before a new op is accepted).
REQ-023: Abort: start=0 sampled while in BUSY -> IDLE next edge; no done; result keeps previous value.
REQ-024: result SHALL update only on the edge entering DONE; otherwise hold.
REQ-025: No back-to-back ops without at least one cycle of start=0 between them.

Reset
REQ-026: reset=1 at any edge forces state IDLE, done=0, result=16'h0000, counter=0, latched operands/op=0; takes priority over all other inputs.
REQ-027: reset mid-operation (BUSY or DONE) SHALL discard the op; no done pulse after reset deasserts.
REQ-028: First capture possible on the first edge with reset=0 and start=1.

Verification
REQ-029: add_op, A=8'hFF, B=8'hFF, start held -> done one cycle after capture, result=16'h01FE; start dropped -> IDLE.
REQ-030: mul_op, A=8'hFF, B=8'hFF, MUL_LATENCY=3 -> done exactly 3 cycles after capture, result=16'hFE01, done high one cycle.
REQ-031: and_op A=8'hF0, B=8'h3C -> 16'h0030; xor_op A=8'hAA, B=8'h0F -> 16'h00A5; A/B changed the cycle after capture -> results unchanged.
REQ-032: no_op one-cycle start pulse, then rst_op start -> no done, result holds prior value 16'h00A5.
REQ-033: mul_op start dropped after 1 BUSY cycle -> no done, IDLE; reset=1 mid-mul on a fresh op -> done=0, result=16'h0000.
REQ-034: op=3'b101 -> done one cycle after capture, result=16'h0000; start held 3 extra cycles -> WAIT_LOW, no second done.

Source files
------------

// File: rtl/tinyalu_responder.sv
// Tiny ALU responder: accepts a start/op/operand request, computes add, and,
// xor or a multi-cycle multiply, and answers with a one-cycle done pulse plus
// a held 16-bit result. The initiator holds start until it sees done. It must
// then drop start before a new operation is accepted.
module tinyalu_responder #(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    // BUSY counts down from this value. DONE is entered on the edge after the
    // counter reaches zero, which gives MUL_LATENCY edges from capture to done.
    localparam logic [2:0] MUL_LOAD = 3'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_s;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [2:0]  op_r;
    logic        capture_s;
    logic        finish_s;
    logic        done_r;
    logic [15:0] result_r;

    // Result of the latched operation. Illegal opcodes return zero so that
    // they still complete.
    function automatic logic [15:0] alu_eval(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [2:0] opc);
        logic [15:0] r;
        case (opc)
            OP_ADD:  r = {7'b0000000, {1'b0, a} + {1'b0, b}};
            OP_AND:  r = {8'h00, a & b};
            OP_XOR:  r = {8'h00, a ^ b};
            OP_MUL:  r = {8'h00, a} * {8'h00, b};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Next-state logic, counter update, and capture/finish strobes
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (op != OP_NOP) && (op != OP_RST)) begin
                    capture_s = 1'b1;
                    state_s   = BUSY;
                    cnt_s     = (op == OP_MUL) ? MUL_LOAD : 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!start) begin
                    // The initiator withdrew the request, so drop the operation silently.
                    state_s = IDLE;
                    cnt_s   = 3'd0;
                end else if (cnt_r == 3'd0) begin
                    state_s  = DONE;
                    finish_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            DONE: begin
                if (start) begin
                    state_s = WAIT_LOW;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_LOW: begin
                if (start) begin
                    state_s = WAIT_LOW;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State and cycle counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Operand latch, so that later changes on A/B/op cannot disturb an operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r  <= 8'h00;
            b_r  <= 8'h00;
            op_r <= 3'b000;
        end else if (capture_s) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= op;
        end else begin
            a_r  <= a_r;
            b_r  <= b_r;
            op_r <= op_r;
        end
    end

    // Registered outputs: done pulses on entry to DONE, and result loads only then
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r   <= 1'b0;
            result_r <= 16'h0000;
        end else begin
            done_r <= finish_s;
            if (finish_s) begin
                result_r <= alu_eval(a_r, b_r, op_r);
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_tinyalu_responder.sv
// Directed bench for tinyalu_responder (MUL_LATENCY = 3). Inputs change and
// outputs are checked 1 ns after each rising edge.
module tb_tinyalu_responder;

    logic        clk;
    logic        reset;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int vectors;
    int miscompares;

    tinyalu_responder #(.MUL_LATENCY(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic exp_done, input logic [15:0] exp_res);
        vectors++;
        assert (done === exp_done) else begin
            miscompares++;
            $error("FAIL %s done: observed %b expected %b", tag, done, exp_done);
        end
        vectors++;
        assert (result === exp_res) else begin
            miscompares++;
            $error("FAIL %s result: observed %h expected %h", tag, result, exp_res);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1; A = 8'h00; B = 8'h00; op = 3'b000; start = 1'b1;
        tick(); tick();
        check("reset", 1'b0, 16'h0000);

        // add FF+FF, captured on the first edge after reset
        reset = 1'b0; op = 3'b001; A = 8'hFF; B = 8'hFF; start = 1'b1;
        tick(); check("add_cap", 1'b0, 16'h0000);
        tick(); check("add_done", 1'b1, 16'h01FE);
        start = 1'b0;
        tick(); check("add_idle", 1'b0, 16'h01FE);

        // add with no carry
        op = 3'b001; A = 8'h12; B = 8'h34; start = 1'b1;
        tick(); tick(); check("add2_done", 1'b1, 16'h0046);
        start = 1'b0; tick();

        // mul FF*FF, with start held afterwards to reach WAIT_LOW
        op = 3'b100; A = 8'hFF; B = 8'hFF; start = 1'b1;
        tick(); check("mul_k", 1'b0, 16'h0046);
        tick(); check("mul_k1", 1'b0, 16'h0046);
        tick(); check("mul_k2", 1'b0, 16'h0046);
        tick(); check("mul_done", 1'b1, 16'hFE01);
        tick(); check("mul_wait1", 1'b0, 16'hFE01);
        tick(); check("mul_wait2", 1'b0, 16'hFE01);
        start = 1'b0;
        tick(); check("mul_idle", 1'b0, 16'hFE01);

        // mul 0F*11, with operands changed after capture
        op = 3'b100; A = 8'h0F; B = 8'h11; start = 1'b1;
        tick(); A = 8'hFF; B = 8'hFF; op = 3'b001;
        tick(); tick(); check("mul2_k2", 1'b0, 16'hFE01);
        tick(); check("mul2_done", 1'b1, 16'h00FF);
        start = 1'b0; tick();

        // and, with A/B changed the cycle after capture
        op = 3'b010; A = 8'hF0; B = 8'h3C; start = 1'b1;
        tick(); A = 8'h00; B = 8'h00;
        tick(); check("and_done", 1'b1, 16'h0030);
        start = 1'b0; tick();

        // xor, with A/B/op changed after capture
        op = 3'b011; A = 8'hAA; B = 8'h0F; start = 1'b1;
        tick(); A = 8'h55; B = 8'hFF; op = 3'b001;
        tick(); check("xor_done", 1'b1, 16'h00A5);
        start = 1'b0;
        tick(); check("xor_idle", 1'b0, 16'h00A5);

        // no_op pulse, then rst_op held
        op = 3'b000; A = 8'h11; B = 8'h22; start = 1'b1;
        tick(); start = 1'b0;
        tick(); check("nop", 1'b0, 16'h00A5);
        op = 3'b111; start = 1'b1;
        tick(); tick(); check("rstop", 1'b0, 16'h00A5);
        start = 1'b0; tick();

        // mul aborted after one BUSY cycle
        op = 3'b100; A = 8'h02; B = 8'h03; start = 1'b1;
        tick(); tick(); start = 1'b0;
        tick(); check("abort1", 1'b0, 16'h00A5);
        tick(); check("abort2", 1'b0, 16'h00A5);
        tick(); check("abort3", 1'b0, 16'h00A5);

        // reset in the middle of a fresh mul
        op = 3'b100; A = 8'h05; B = 8'h07; start = 1'b1;
        tick(); tick(); reset = 1'b1; start = 1'b0;
        tick(); check("rst_mid", 1'b0, 16'h0000);
        reset = 1'b0;
        tick(); check("rst_after1", 1'b0, 16'h0000);
        tick(); check("rst_after2", 1'b0, 16'h0000);
        tick(); check("rst_after3", 1'b0, 16'h0000);

        // illegal op 101, with start held three extra cycles
        op = 3'b101; A = 8'h12; B = 8'h34; start = 1'b1;
        tick(); check("ill_cap", 1'b0, 16'h0000);
        tick(); check("ill_done", 1'b1, 16'h0000);
        tick(); check("ill_wait1", 1'b0, 16'h0000);
        tick(); check("ill_wait2", 1'b0, 16'h0000);
        tick(); check("ill_wait3", 1'b0, 16'h0000);
        start = 1'b0; tick();

        // illegal op 110 after a result is set, to show that it clears to zero
        op = 3'b011; A = 8'h0F; B = 8'hF0; start = 1'b1;
        tick(); tick(); check("xor2_done", 1'b1, 16'h00FF);
        start = 1'b0; tick();
        op = 3'b110; start = 1'b1;
        tick(); tick(); check("ill110_done", 1'b1, 16'h0000);
        start = 1'b0;
        tick(); check("ill110_idle", 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
